// File: rtl/clk_step_ctrl.sv
// Run/halt/single-step controller for the MIPS core clock enable.
// Turns the divided clock into a 1-cycle o_cpu_en pulse, gated by a
// run/halt/step FSM driven from debounced front-panel buttons.
// Optional breakpoint halt: define STEP_CTRL_BREAKPOINT_EN.
module clk_step_ctrl #(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 32,
    parameter int PC_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_div_clk,
    input  logic             i_run_btn,
    input  logic             i_step_btn,
    input  logic             i_halt_btn,
    input  logic [PC_W-1:0]  i_pc,
    input  logic [PC_W-1:0]  i_bp_addr,
    input  logic             i_bp_valid,
    output logic             o_cpu_en,
    output logic [1:0]       o_state,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_cycle_cnt
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HALT = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_BRK  = 2'b11
    } state_t;

    state_t          state, state_next;
    logic            div_q, tick;
    logic [2:0]      btn_raw, sync1, sync2, deb, deb_q, press;
    logic [DW-1:0]   deb_cnt [3];
    logic            halt_ev, step_ev, run_ev;
    logic            en_next, halted_next;

`ifdef STEP_CTRL_BREAKPOINT_EN
    logic            skip, skip_next, bp_hit;
    assign bp_hit = i_bp_valid && (i_pc == i_bp_addr) && !skip;
`else
    logic            unused_bp;
    assign unused_bp = ^{i_pc, i_bp_addr, i_bp_valid};
`endif

    // bit 0 run, bit 1 step, bit 2 halt
    assign btn_raw = {i_halt_btn, i_step_btn, i_run_btn};
    assign press   = deb & ~deb_q;
    assign halt_ev = press[2];
    assign step_ev = press[1];
    assign run_ev  = press[0];
    assign tick    = i_div_clk & ~div_q;
    assign o_state = state;

    // Button synchronisers and counter-based debounce
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int unsigned i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_MAX) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Next-state and pulse decision; event priority halt > step > run
    always_comb begin
        state_next = state;
        en_next    = 1'b0;
`ifdef STEP_CTRL_BREAKPOINT_EN
        skip_next  = skip;
`endif
        case (state)
            S_HALT: begin
                if (halt_ev)      state_next = S_HALT;
                else if (step_ev) state_next = S_STEP;
                else if (run_ev)  state_next = S_RUN;
            end
            S_RUN: begin
                if (halt_ev) begin
                    state_next = S_HALT;
                end else if (tick) begin
`ifdef STEP_CTRL_BREAKPOINT_EN
                    if (bp_hit) begin
                        state_next = S_BRK;
                    end else begin
                        en_next   = 1'b1;
                        skip_next = 1'b0;
                    end
`else
                    en_next = 1'b1;
`endif
                end
            end
            S_STEP: begin
                if (halt_ev) begin
                    state_next = S_HALT;
                end else if (tick) begin
                    en_next    = 1'b1;
                    state_next = S_HALT;
                end
            end
`ifdef STEP_CTRL_BREAKPOINT_EN
            S_BRK: begin
                if (halt_ev) begin
                    state_next = S_HALT;
                end else if (step_ev) begin
                    state_next = S_STEP;
                    skip_next  = 1'b1;
                end else if (run_ev) begin
                    state_next = S_RUN;
                    skip_next  = 1'b1;
                end
            end
`endif
            default: state_next = S_HALT;
        endcase
`ifdef STEP_CTRL_BREAKPOINT_EN
        // skip only covers the first tick after leaving BRK
        if (state_next == S_HALT) skip_next = 1'b0;
`endif
        halted_next = (state_next == S_HALT) || (state_next == S_BRK);
    end

    // State, registered outputs, tick history and cycle counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_HALT;
            div_q       <= 1'b0;
            o_cpu_en    <= 1'b0;
            o_halted    <= 1'b1;
            o_cycle_cnt <= '0;
`ifdef STEP_CTRL_BREAKPOINT_EN
            skip        <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            div_q    <= i_div_clk;
            o_cpu_en <= en_next;
            o_halted <= halted_next;
            if (o_cpu_en) o_cycle_cnt <= o_cycle_cnt + 1'b1;
`ifdef STEP_CTRL_BREAKPOINT_EN
            skip     <= skip_next;
`endif
        end
    end

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Self-checking bench for clk_step_ctrl: random button traffic against
// a behavioural model. Honours STEP_CTRL_BREAKPOINT_EN when defined.
module tb_clk_step_ctrl;

    localparam int DEB  = 4;
    localparam int CW   = 4;
    localparam int PW   = 8;
    localparam int DIVP = 7;
`ifdef STEP_CTRL_BREAKPOINT_EN
    localparam bit BP_ON = 1'b1;
`else
    localparam bit BP_ON = 1'b0;
`endif
    localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2, M_BRK = 3;

    logic          clk = 1'b0;
    logic          rst, div, run_b, step_b, halt_b, bp_valid;
    logic [PW-1:0] pc, bp_addr;
    logic          cpu_en, halted;
    logic [1:0]    state;
    logic [CW-1:0] cycle_cnt;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b0;
    int divc = 0;

    clk_step_ctrl #(.DEB_CYCLES(DEB), .CNT_W(CW), .PC_W(PW)) dut (
        .i_clk(clk), .i_rst(rst), .i_div_clk(div),
        .i_run_btn(run_b), .i_step_btn(step_b), .i_halt_btn(halt_b),
        .i_pc(pc), .i_bp_addr(bp_addr), .i_bp_valid(bp_valid),
        .o_cpu_en(cpu_en), .o_state(state), .o_halted(halted),
        .o_cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int ms = M_HALT;
    bit men = 1'b0;
    int mcnt = 0;
    bit mskip = 1'b0;
    bit mdivp = 1'b0;
    bit mdeb[3];
    bit mdebp[3];
    bit rawq[3][$];
    bit synq[3][$];

    // Model advance at each rising edge using the inputs the DUT also sees
    always @(posedge clk) begin
        bit raw[3];
        bit pr[3];
        bit tk, pulse, syn, all_diff;
        int nxt;
        raw[0] = run_b; raw[1] = step_b; raw[2] = halt_b;
        if (rst) begin
            ms = M_HALT; men = 1'b0; mcnt = 0; mskip = 1'b0; mdivp = 1'b0;
            for (int b = 0; b < 3; b++) begin
                mdeb[b] = 1'b0; mdebp[b] = 1'b0;
                rawq[b].delete(); synq[b].delete();
            end
        end else begin
            for (int b = 0; b < 3; b++) pr[b] = mdeb[b] && !mdebp[b];
            tk = div && !mdivp;
            nxt = ms;
            pulse = 1'b0;
            case (ms)
                M_HALT: begin
                    if (pr[2]) nxt = M_HALT;
                    else if (pr[1]) nxt = M_STEP;
                    else if (pr[0]) nxt = M_RUN;
                end
                M_RUN: begin
                    if (pr[2]) nxt = M_HALT;
                    else if (tk) begin
                        if (BP_ON && !mskip && bp_valid && pc == bp_addr) nxt = M_BRK;
                        else begin pulse = 1'b1; mskip = 1'b0; end
                    end
                end
                M_STEP: begin
                    if (pr[2]) nxt = M_HALT;
                    else if (tk) begin pulse = 1'b1; nxt = M_HALT; end
                end
                default: begin
                    if (pr[2]) nxt = M_HALT;
                    else if (pr[1]) begin nxt = M_STEP; mskip = 1'b1; end
                    else if (pr[0]) begin nxt = M_RUN; mskip = 1'b1; end
                end
            endcase
            if (nxt == M_HALT) mskip = 1'b0;
            if (men) mcnt = (mcnt + 1) % (1 << CW);
            men = pulse;
            ms = nxt;
            mdivp = div;
            for (int b = 0; b < 3; b++) begin
                mdebp[b] = mdeb[b];
                // synchronised sample is the raw level from two edges ago
                rawq[b].push_back(raw[b]);
                syn = (rawq[b].size() >= 3) ? rawq[b][rawq[b].size()-3] : 1'b0;
                while (rawq[b].size() > 3) void'(rawq[b].pop_front());
                synq[b].push_back(syn);
                while (synq[b].size() > DEB) void'(synq[b].pop_front());
                all_diff = (synq[b].size() == DEB);
                for (int i = 0; i < synq[b].size(); i++)
                    if (synq[b][i] == mdeb[b]) all_diff = 1'b0;
                if (all_diff) begin
                    mdeb[b] = syn;
                    synq[b].delete();
                end
            end
        end
    end

    // Divider, core PC and output checks on the falling edge
    always @(negedge clk) begin
        if (chk_on) begin
            check("state", 32'(state), 32'(ms));
            check("cpu_en", 32'(cpu_en), 32'(men));
            check("halted", 32'(halted), 32'((ms == M_HALT) || (ms == M_BRK)));
            check("cycle_cnt", 32'(cycle_cnt), 32'(mcnt));
        end
        if (cpu_en === 1'b1) pc = pc + 1'b1;
        divc = (divc == DIVP - 1) ? 0 : divc + 1;
        div = (divc == 0);
    end

    task automatic press(input bit [2:0] mask, input int hold, input int gap);
        run_b = mask[0]; step_b = mask[1]; halt_b = mask[2];
        repeat (hold) @(negedge clk);
        run_b = 1'b0; step_b = 1'b0; halt_b = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        int r;
        rst = 1'b1; div = 1'b0; run_b = 1'b0; step_b = 1'b0; halt_b = 1'b0;
        pc = '0; bp_addr = 8'h10; bp_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        rst = 1'b0;
        repeat (100) @(negedge clk);
        press(3'b001, 10, 100);
        press(3'b110, 10, 40);
        press(3'b001, 10, 30);
        press(3'b100, 10, 30);
        for (int k = 0; k < 3; k++) press(3'b010, 10, 30);
        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) begin
                bp_addr = PW'($urandom_range(0, 255));
                bp_valid = $urandom_range(0, 1);
            end
            case (r)
                0, 1, 2: press(3'b001, $urandom_range(8, 20), $urandom_range(5, 60));
                3, 4:    press(3'b010, $urandom_range(8, 20), $urandom_range(5, 60));
                5, 6:    press(3'b100, $urandom_range(8, 20), $urandom_range(5, 60));
                7:       press(3'b110, $urandom_range(8, 20), $urandom_range(5, 60));
                8:       press(3'($urandom_range(1, 7)), $urandom_range(1, DEB - 1), $urandom_range(5, 20));
                default: begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    repeat ($urandom_range(5, 30)) @(negedge clk);
                end
            endcase
        end
        repeat (20) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
